// File: rtl/rr_grant_encoder_pkg.sv
// Shared constants and helpers for the round-robin grant encoder.
// FSM state encodings are kept as plain localparams for compatibility with older flows.
package rr_grant_encoder_pkg;

  localparam int DEF_N        = 8;
  localparam int DEF_HOLD_MAX = 15;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  localparam int DEF_IW = clog2(DEF_N);

endpackage

// File: rtl/rr_grant_encoder_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_encoder_if #(
  parameter int N  = 8,
  parameter int IW = 3
);
  logic [N-1:0]  req;
  logic          done;
  logic [IW-1:0] a;
  logic          gnt_vld;
  logic          timeout;

  modport master (output req, done, input a, gnt_vld, timeout);
  modport slave  (input req, done, output a, gnt_vld, timeout);
endinterface

// File: rtl/rr_grant_encoder_pick.sv
// Combinational round-robin pick: first set request strictly after ptr, circularly.
// Rotate so ptr+1 lands at bit 0, take the lowest set bit, then rotate the index back.
module rr_grant_encoder_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0]  start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  enc;

  // N is a power of two, so IW-bit arithmetic wraps modulo N for free.
  assign start = ptr_i + IW'(1);
  assign dbl   = {req_i, req_i} >> start;
  assign rot   = dbl[N-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IW'(i);
    end
  end

  assign idx_o = enc + start;
  assign any_o = |req_i;

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter producing a registered binary grant index for a one-hot decoder.
// Grants are held until done, requester drop or the hold limit, then priority rotates.
module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IW       = clog2(N),
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic                clk,
  input  logic                rst,
  rr_grant_encoder_if.slave   bus
);

  localparam int CW = clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] a_q, a_d;
  logic          vld_q, vld_d;
  logic          timeout_q, timeout_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_grant_encoder_pick #(.N(N), .IW(IW)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    vld_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          a_d     = pick_idx;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      default: begin
        // Exit priority: done, then requester drop, then hold limit.
        if (bus.done || !bus.req[a_q] || cnt_q == CNT_LAST) begin
          timeout_d = !bus.done && bus.req[a_q];
          ptr_d     = a_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          vld_d = 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IW'(N - 1);
      cnt_q     <= '0;
      a_q       <= '0;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      vld_q     <= vld_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.a       = a_q;
  assign bus.gnt_vld = vld_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: a vector table for reset, rotation and release,
// plus hand sequences for hold-limit timeout, requester drop, done-vs-limit and mid-grant reset.
module tb_rr_grant_encoder;

  logic clk;
  logic rst;

  rr_grant_encoder_if #(.N(8), .IW(3)) bus ();

  rr_grant_encoder #(.N(8), .IW(3), .HOLD_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] a;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Downstream one-hot decoder driven from the grant index.
  logic [7:0] y;
  always_comb begin
    y = '0;
    y[bus.a] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] ea, input logic ev, input logic et);
    logic [7:0] onehot;
    check({tag, " gnt_vld"}, 32'(bus.gnt_vld), 32'(ev));
    check({tag, " timeout"}, 32'(bus.timeout), 32'(et));
    if (ev) begin
      check({tag, " a"}, 32'(bus.a), 32'(ea));
      onehot = 8'h01 << ea;
      check({tag, " decoder y"}, 32'(y), 32'(onehot));
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic d);
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic [7:0] rq, input logic d,
                              input logic [2:0] ea, input logic ev, input logic et);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.a = ea; v.vld = ev; v.to = et;
    vecs.push_back(v);
  endfunction

  initial begin
    int hi;
    bit released;

    rst = 1'b1;
    bus.req = 8'hFF;
    bus.done = 1'b0;

    // Reset held two cycles with all requests set, then first grant from index 0.
    add(1, 8'hFF, 0, 3'd0, 0, 0);
    add(1, 8'hFF, 0, 3'd0, 0, 0);
    add(0, 8'hFF, 0, 3'd0, 1, 0);
    // Full rotation 0..7 then wrap to 0, one bubble between grants.
    for (int k = 1; k <= 8; k++) begin
      add(0, 8'hFF, 1, 3'(k - 1), 0, 0);
      add(0, 8'hFF, 0, 3'(k % 8), 1, 0);
    end
    add(0, 8'hFF, 1, 3'd0, 0, 0);
    // Single requester 4: three grant cycles, done, bubble, re-grant.
    add(0, 8'h10, 0, 3'd4, 1, 0);
    add(0, 8'h10, 0, 3'd4, 1, 0);
    add(0, 8'h10, 0, 3'd4, 1, 0);
    add(0, 8'h10, 1, 3'd4, 0, 0);
    add(0, 8'h10, 0, 3'd4, 1, 0);
    add(0, 8'h10, 1, 3'd4, 0, 0);
    // done in IDLE with no requests is ignored.
    add(0, 8'h00, 1, 3'd4, 0, 0);
    add(0, 8'h00, 0, 3'd4, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check_out($sformatf("vec%0d", i), vecs[i].a, vecs[i].vld, vecs[i].to);
    end

    // Hold limit: requester 2 held without done.
    step(0, 8'h04, 0);
    check_out("hold grant", 3'd2, 1, 0);
    hi = 1;
    released = 1'b0;
    for (int c = 0; c < 40 && !released; c++) begin
      step(0, 8'h04, 0);
      if (bus.gnt_vld) hi++;
      else released = 1'b1;
    end
    check("hold released", 32'(released), 32'd1);
    check("hold cycles", 32'(hi), 32'd15);
    check("hold timeout pulse", 32'(bus.timeout), 32'd1);
    step(0, 8'h04, 0);
    check_out("hold regrant", 3'd2, 1, 0);

    // Requester drop releases without timeout.
    step(0, 8'h00, 0);
    check_out("drop2", 3'd2, 0, 0);
    step(0, 8'h08, 0);
    check_out("grant3", 3'd3, 1, 0);
    step(0, 8'h08, 0);
    step(0, 8'h08, 0);
    check_out("grant3 hold", 3'd3, 1, 0);
    step(0, 8'h00, 0);
    check_out("drop3", 3'd3, 0, 0);

    // done coinciding with the last hold cycle wins; no timeout pulse.
    step(0, 8'h08, 0);
    check_out("grant3b", 3'd3, 1, 0);
    for (int c = 0; c < 14; c++) step(0, 8'h08, 0);
    check_out("cnt14", 3'd3, 1, 0);
    step(0, 8'h08, 1);
    check_out("done at limit", 3'd3, 0, 0);
    step(0, 8'h08, 0);
    check_out("regrant3", 3'd3, 1, 0);
    step(0, 8'h08, 1);
    check_out("release3", 3'd3, 0, 0);

    // Mid-grant reset restores a=0 and the pointer.
    step(0, 8'h20, 0);
    check_out("grant5", 3'd5, 1, 0);
    step(0, 8'h21, 0);
    check_out("grant5 hold", 3'd5, 1, 0);
    step(1, 8'h21, 0);
    check_out("reset mid", 3'd0, 0, 0);
    check("reset a", 32'(bus.a), 32'd0);
    step(0, 8'h21, 0);
    check_out("after reset", 3'd0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
